// File: rtl/aes_pkg.sv
// Shared AES definitions: mode encodings, Nk/Nr lookups, GF(2^8) helpers and the forward S-box.
// The S-box is computed as multiplicative inverse (x^254) followed by the FIPS-197 affine map.
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_AES128  = 2'd0,
        MODE_AES192  = 2'd1,
        MODE_AES256  = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GEN_SUB,
        ST_GEN_XOR,
        ST_EMIT
    } state_e;

    localparam int         RK_W      = 128;
    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        logic [3:0] nk;
        case (mode)
            2'd0:    nk = 4'd4;
            2'd1:    nk = 4'd6;
            default: nk = 4'd8;
        endcase
        return nk;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        return nk_of(mode) + 4'd6;
    endfunction

    function automatic int key_bits_of(input logic [1:0] mode);
        return 128 + 64 * int'(mode);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        // x^254 is the inverse in GF(2^8); zero maps to zero as required
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Four registered forward S-box lanes applied bytewise to a 32-bit word.
// One-cycle latency; output holds while en_i is low.
module aes_subword
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    logic [31:0] word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else if (en_i) begin
            for (int l = 0; l < 4; l++) begin
                word_q[8*l +: 8] <= sbox(word_i[8*l +: 8]);
            end
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/key_expansion_engine.sv
// AES-128/192/256 key schedule generating one word per two cycles and streaming 128-bit round keys.
// Loads Nk cycles, 2 cycles per generated word, 1 cycle per round key; stalls fully while RK_READY is low.
module key_expansion_engine
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256,
    parameter int RK_IDX_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    START,
    input  logic [1:0]              MODE,
    input  logic [MAX_KEY_BITS-1:0] IN_KEY,
    input  logic                    ABORT,
    output logic                    READY,
    output logic                    RK_VALID,
    input  logic                    RK_READY,
    output logic [RK_IDX_W-1:0]     RK_INDEX,
    output logic [RK_W-1:0]         RK_DATA,
    output logic                    DONE,
    output logic                    ERR
);

    state_e                    state_q, state_d;
    logic [MAX_KEY_BITS-1:0]   key_q, key_d;
    logic [7:0][31:0]          win_q, win_d;
    logic [RK_W-1:0]           acc_q, acc_d;
    logic [2:0]                acc_cnt_q, acc_cnt_d;
    logic [5:0]                wcnt_q, wcnt_d;
    logic [2:0]                pos_q, pos_d;
    logic [2:0]                nk_m1_q, nk_m1_d;
    logic [3:0]                nr_q, nr_d;
    logic [7:0]                rcon_q, rcon_d;
    logic [RK_IDX_W-1:0]       rk_idx_q, rk_idx_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic        legal;
    logic        rot_step, sub_step;
    logic [31:0] temp, sub_in, sub_out, sub_mix, gen_word, new_word;
    logic        shift_en;

    // win_q[0] is the newest word w[i-1], so w[i-Nk] sits at win_q[Nk-1]
    assign temp     = win_q[0];
    assign rot_step = (pos_q == 3'd0);
    assign sub_step = (nk_m1_q == 3'd7) && (pos_q == 3'd4);
    assign sub_in   = rot_step ? {temp[23:0], temp[31:24]} : temp;
    assign legal    = (MODE != MODE_ILLEGAL) && (key_bits_of(MODE) <= MAX_KEY_BITS);

    aes_subword u_subword (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == ST_GEN_SUB),
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        if (rot_step)      sub_mix = sub_out ^ {rcon_q, 24'h0};
        else if (sub_step) sub_mix = sub_out;
        else               sub_mix = temp;
    end

    assign gen_word = win_q[nk_m1_q] ^ sub_mix;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        win_d     = win_q;
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        wcnt_d    = wcnt_q;
        pos_d     = pos_q;
        nk_m1_d   = nk_m1_q;
        nr_d      = nr_q;
        rcon_d    = rcon_q;
        rk_idx_d  = rk_idx_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        shift_en  = 1'b0;
        new_word  = key_q[MAX_KEY_BITS-1 -: 32];

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (legal) begin
                        key_d     = IN_KEY;
                        nk_m1_d   = 3'(nk_of(MODE) - 4'd1);
                        nr_d      = nr_of(MODE);
                        rcon_d    = RCON_INIT;
                        acc_cnt_d = '0;
                        wcnt_d    = '0;
                        pos_d     = '0;
                        rk_idx_d  = '0;
                        state_d   = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                shift_en = 1'b1;
                key_d    = key_q << 32;
                if (acc_cnt_q == 3'd3)                  state_d = ST_EMIT;
                else if (wcnt_q == {3'b000, nk_m1_q})   state_d = ST_GEN_SUB;
            end
            ST_GEN_SUB: begin
                state_d = ST_GEN_XOR;
            end
            ST_GEN_XOR: begin
                shift_en = 1'b1;
                new_word = gen_word;
                if (rot_step) rcon_d = xtime(rcon_q);
                state_d = (acc_cnt_q == 3'd3) ? ST_EMIT : ST_GEN_SUB;
            end
            ST_EMIT: begin
                if (RK_READY) begin
                    acc_cnt_d = '0;
                    rk_idx_d  = rk_idx_q + RK_IDX_W'(1);
                    if (rk_idx_q == RK_IDX_W'(nr_q)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (wcnt_q <= {3'b000, nk_m1_q}) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_GEN_SUB;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (shift_en) begin
            win_d     = {win_q[6:0], new_word};
            acc_d     = {acc_q[RK_W-33:0], new_word};
            acc_cnt_d = acc_cnt_q + 3'd1;
            wcnt_d    = wcnt_q + 6'd1;
            pos_d     = (pos_q == nk_m1_q) ? 3'd0 : pos_q + 3'd1;
        end

        // abort beats a same-cycle handshake: the key on the bus is not counted
        if (ABORT && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            rk_idx_d = rk_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            key_q     <= '0;
            win_q     <= '0;
            acc_q     <= '0;
            acc_cnt_q <= '0;
            wcnt_q    <= '0;
            pos_q     <= '0;
            nk_m1_q   <= '0;
            nr_q      <= '0;
            rcon_q    <= RCON_INIT;
            rk_idx_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            win_q     <= win_d;
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            wcnt_q    <= wcnt_d;
            pos_q     <= pos_d;
            nk_m1_q   <= nk_m1_d;
            nr_q      <= nr_d;
            rcon_q    <= rcon_d;
            rk_idx_q  <= rk_idx_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign READY    = (state_q == ST_IDLE);
    assign RK_VALID = (state_q == ST_EMIT);
    assign RK_INDEX = rk_idx_q;
    assign RK_DATA  = acc_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule
